// File: rtl/bram_bank.sv
// Banked behavioural block RAM: NUM_UNITS units of BRAM_DEPTH words, NO_CHANGE reads, bit-masked writes and a whole-bank zero-fill.
// Optional per-word even parity is enabled by defining BRAM_BANK_PARITY_EN.
module bram_bank #(
  parameter int BRAM_DEPTH = 512,
  parameter int BRAM_WIDTH = 64,
  parameter int NUM_UNITS  = 4,
  parameter int OUT_REG    = 0,
  localparam int BANK_ADDR_WIDTH = $clog2(BRAM_DEPTH * NUM_UNITS)
) (
  input  logic                       bram_clk,
  input  logic                       bram_rst,
  input  logic                       bram_chip_en,
  input  logic                       bram_wr_en,
  input  logic [BANK_ADDR_WIDTH-1:0] bram_addr,
  input  logic [BRAM_WIDTH-1:0]      bram_wdata,
  input  logic [BRAM_WIDTH-1:0]      bram_mask,
  input  logic                       bram_clr_req,
  input  logic                       bram_perr_inject,
  output logic [BRAM_WIDTH-1:0]      bram_rdata,
  output logic                       bram_rvalid,
  output logic                       bram_busy,
  output logic                       bram_perr
);

  localparam int WORD_W = $clog2(BRAM_DEPTH);
  localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(BRAM_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [WORD_W-1:0]    clr_idx_q, clr_idx_d;

  logic [BRAM_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  perr_q, perr_d;

  logic [BRAM_WIDTH-1:0] mem [NUM_UNITS][BRAM_DEPTH];

  logic [WORD_W-1:0]     word_idx;
  logic [UNIT_W-1:0]     unit_idx;
  logic                  access_ok;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [BRAM_WIDTH-1:0] cur_word;
  logic [BRAM_WIDTH-1:0] new_word;
  logic                  rd_perr;

  logic                  src_vld;
  logic [BRAM_WIDTH-1:0] src_data;
  logic                  src_perr;

  assign word_idx = bram_addr[WORD_W-1:0];

  generate
    if (NUM_UNITS > 1) begin : g_unit_sel
      assign unit_idx = bram_addr[WORD_W +: UNIT_W];
    end else begin : g_unit_single
      assign unit_idx = '0;
    end
  endgenerate

  // A clear request wins over any access presented in the same cycle.
  assign access_ok = bram_chip_en && (state_q == IDLE) && !bram_clr_req;
  assign wr_fire   = access_ok && bram_wr_en;
  assign rd_fire   = access_ok && !bram_wr_en;
  assign cur_word  = mem[unit_idx][word_idx];
  assign new_word  = (cur_word & ~bram_mask) | (bram_wdata & bram_mask);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (bram_clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Array contents carry no reset; only the clear sweep zeroes them.
  always_ff @(posedge bram_clk) begin
    if (!bram_rst) begin
      if (state_q == CLEAR) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          mem[UNIT_W'(u)][clr_idx_q] <= '0;
        end
      end else if (wr_fire) begin
        mem[unit_idx][word_idx] <= new_word;
      end
    end
  end

`ifdef BRAM_BANK_PARITY_EN
  logic par [NUM_UNITS][BRAM_DEPTH];

  // Stored bit makes word plus parity even; inject flips it to force an error.
  always_ff @(posedge bram_clk) begin
    if (!bram_rst) begin
      if (state_q == CLEAR) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          par[UNIT_W'(u)][clr_idx_q] <= 1'b0;
        end
      end else if (wr_fire) begin
        par[unit_idx][word_idx] <= (^new_word) ^ bram_perr_inject;
      end
    end
  end

  assign rd_perr = (^cur_word) ^ par[unit_idx][word_idx];
`else
  logic unused_perr_inject;
  assign unused_perr_inject = bram_perr_inject;
  assign rd_perr = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  vld_p0_q, vld_p0_d;
      logic [BRAM_WIDTH-1:0] data_p0_q, data_p0_d;
      logic                  perr_p0_q, perr_p0_d;

      always_comb begin
        vld_p0_d  = rd_fire;
        data_p0_d = rd_fire ? cur_word : data_p0_q;
        perr_p0_d = rd_perr;
      end

      // Stage p0: raw array word, one cycle ahead of the output register.
      always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
          vld_p0_q <= 1'b0;
        end else begin
          vld_p0_q <= vld_p0_d;
        end
      end

      always_ff @(posedge bram_clk) begin
        data_p0_q <= data_p0_d;
        perr_p0_q <= perr_p0_d;
      end

      assign src_vld  = vld_p0_q;
      assign src_data = data_p0_q;
      assign src_perr = perr_p0_q;
    end else begin : g_no_out_reg
      assign src_vld  = rd_fire;
      assign src_data = cur_word;
      assign src_perr = rd_perr;
    end
  endgenerate

  // Output stage: data only moves on a read, so writes leave rdata untouched.
  always_comb begin
    rvalid_d = src_vld;
    rdata_d  = src_vld ? src_data : rdata_q;
    perr_d   = src_vld & src_perr;
  end

  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      perr_q   <= perr_d;
    end
  end

  assign bram_rdata  = rdata_q;
  assign bram_rvalid = rvalid_q;
  assign bram_perr   = perr_q;
  assign bram_busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_bram_bank.sv
// Self-checking bench for bram_bank: directed scenarios plus random traffic against a word-array reference model.
module tb_bram_bank;
  localparam int DEPTH   = 512;
  localparam int WIDTH   = 64;
  localparam int UNITS   = 4;
  localparam int OUT_REG = 0;
  localparam int AW      = $clog2(DEPTH * UNITS);
`ifdef BRAM_BANK_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, ce, we, clr, inj;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata, mask, rdata;
  logic             rvalid, busy, perr;

  always #5 clk = ~clk;

  bram_bank #(.BRAM_DEPTH(DEPTH), .BRAM_WIDTH(WIDTH), .NUM_UNITS(UNITS), .OUT_REG(OUT_REG)) dut (
    .bram_clk(clk), .bram_rst(rst), .bram_chip_en(ce), .bram_wr_en(we), .bram_addr(addr),
    .bram_wdata(wdata), .bram_mask(mask), .bram_clr_req(clr), .bram_perr_inject(inj),
    .bram_rdata(rdata), .bram_rvalid(rvalid), .bram_busy(busy), .bram_perr(perr)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    bit               bad;
    int               dly;
  } rd_t;

  logic [WIDTH-1:0] m_mem [DEPTH*UNITS];
  bit               m_bad [DEPTH*UNITS];
  int               m_busy;
  logic [WIDTH-1:0] m_rdata;
  bit               m_rv, m_perr;
  rd_t              pend[$];
  logic [WIDTH-1:0] got[$];
  int               n_pass, n_fail, n_total, busy_seen;

  function automatic void m_zero();
    for (int i = 0; i < DEPTH*UNITS; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk1({tag, ".rvalid"}, rvalid, m_rv);
    chk1({tag, ".busy"}, busy, (rst === 1'b1) || (m_busy > 0));
    chk1({tag, ".perr"}, perr, m_perr);
    chkw({tag, ".rdata"}, rdata, m_rdata);
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cyc(input bit c, input bit w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                     input logic [WIDTH-1:0] mk, input bit cl, input bit ij, input string tag);
    ce = c; we = w; addr = a; wdata = d; mask = mk; clr = cl; inj = ij;
    if (busy === 1'b1) busy_seen++;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (m_busy > 0) begin
        m_busy--;
      end else if (cl) begin
        m_busy = DEPTH;
        m_zero();
      end else if (c && w) begin
        m_mem[a] = (m_mem[a] & ~mk) | (d & mk);
        m_bad[a] = PAR & ij;
      end else if (c) begin
        pend.push_back('{d: m_mem[a], bad: m_bad[a], dly: OUT_REG});
      end
      m_rv = 1'b0;
      m_perr = 1'b0;
      if (pend.size() > 0 && pend[0].dly == 0) begin
        m_rv = 1'b1;
        m_rdata = pend[0].d;
        m_perr = pend[0].bad;
        void'(pend.pop_front());
      end
      for (int i = 0; i < pend.size(); i++) pend[i].dly = pend[i].dly - 1;
    end
    if (rvalid === 1'b1) got.push_back(rdata);
    check_outs(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, '0, '0, '0, 0, 0, "idle");
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag);
    cyc(1, 0, a, '0, '0, 0, 0, tag);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] mk,
                    input bit ij, input string tag);
    cyc(1, 1, a, d, mk, 0, ij, tag);
  endtask

  // Bounded by a cycle budget so a stuck busy still reaches the summary.
  task automatic wait_ready(input string tag);
    int guard = 0;
    while ((m_busy > 0 || busy === 1'b1) && guard < 4 * DEPTH) begin
      cyc(0, 0, '0, '0, '0, 0, 0, tag);
      guard++;
    end
    chk1({tag, ".ready"}, busy, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    m_rdata = '0; m_rv = 1'b0; m_perr = 1'b0; m_busy = DEPTH;
    pend.delete();
    m_zero();
    check_outs({tag, ".async"});
    idle(2);
    rst = 1'b0;
    busy_seen = 0;
  endtask

  logic [WIDTH-1:0] v [4];
  logic [AW-1:0]    ra;

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0; busy_seen = 0;
    ce = 0; we = 0; addr = '0; wdata = '0; mask = '0; clr = 0; inj = 0;

    // Power-on reset and the initial clear.
    do_reset("por");
    wait_ready("por_clear");
    chkn("por_busy_len", busy_seen, DEPTH);
    for (int i = 0; i < 8; i++) rd(AW'($urandom_range(0, DEPTH*UNITS-1)), "rd_zero");
    idle(OUT_REG + 1);

    // Masked write merge.
    wr(AW'(11'h600), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, "wr_ones");
    wr(AW'(11'h600), 64'h0, 64'h0000_0000_FFFF_FFFF, 0, "wr_lo0");
    rd(AW'(11'h600), "rd_600");
    idle(OUT_REG);
    chk1("mask_rvalid", rvalid, 1'b1);
    chkw("mask_rdata", rdata, 64'hFFFF_FFFF_0000_0000);
    idle(1);

    // One read per unit back to back, with a write in the middle.
    for (int i = 0; i < 4; i++) begin
      v[i] = {$urandom, $urandom};
      wr(AW'(5 + i * DEPTH), v[i], '1, 0, "fill_unit");
    end
    got.delete();
    rd(AW'(5), "rd_u0");
    rd(AW'(5 + DEPTH), "rd_u1");
    wr(AW'(200), {$urandom, $urandom}, '1, 0, "wr_between");
    rd(AW'(5 + 2 * DEPTH), "rd_u2");
    rd(AW'(5 + 3 * DEPTH), "rd_u3");
    idle(OUT_REG + 2);
    chkn("unit_strobes", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chkw("unit_order", got[i], v[i]);

    // Random traffic concentrated on a few words of every unit.
    for (int i = 0; i < 400; i++) begin
      ra = {2'($urandom_range(0, 3)), 9'($urandom_range(0, 7))};
      case ($urandom_range(0, 3))
        0: idle(1);
        1: wr(ra, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "rand_wr");
        default: rd(ra, "rand_rd");
      endcase
    end
    idle(OUT_REG + 1);

    // Clear with a same-cycle write dropped, a read in flight, and a second request mid-clear.
    wr(AW'(3), 64'h1234_5678_9ABC_DEF0, '1, 0, "wr3");
    rd(AW'(3), "rd3_inflight");
    busy_seen = 0;
    cyc(1, 1, AW'(3), 64'hDEAD_BEEF_DEAD_BEEF, '1, 1, 0, "clr_with_wr");
    idle(100);
    cyc(0, 0, '0, '0, '0, 1, 0, "clr_again");
    wait_ready("clr");
    chkn("clr_busy_len", busy_seen, DEPTH);
    rd(AW'(3), "rd3_after");
    idle(OUT_REG);
    chk1("clr_rd3_vld", rvalid, 1'b1);
    chkw("clr_rd3", rdata, 64'h0);

    // Reset in the middle of a clear restarts the sweep.
    cyc(0, 0, '0, '0, '0, 1, 0, "clr_for_rst");
    idle(199);
    do_reset("mid_rst");
    wait_ready("mid_rst_clear");
    chkn("rst_busy_len", busy_seen, DEPTH);

`ifdef BRAM_BANK_PARITY_EN
    wr(AW'(7), 64'h0F0F_0000_0000_0001, '1, 1, "wr7_inj");
    rd(AW'(7), "rd7_inj");
    idle(OUT_REG);
    chk1("perr_inj", perr, 1'b1);
    wr(AW'(7), 64'h0F0F_0000_0000_0001, '1, 0, "wr7_clean");
    rd(AW'(7), "rd7_clean");
    idle(OUT_REG);
    chk1("perr_clean", perr, 1'b0);
`endif

    for (int i = 0; i < 20; i++) rd(AW'($urandom_range(0, DEPTH*UNITS-1)), "b2b_rd");
    idle(OUT_REG + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
